// File: rtl/control_unit_pkg.sv
// Shared encodings for the cs147sec05 sequencer: instruction fields, ALU codes,
// sequencer states and CTRL bit positions.
package control_unit_pkg;

  localparam int CTRL_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int ALU_WIDTH   = 6;

  // Opcodes (INSTRUCTION[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;

  // R-type funct codes (INSTRUCTION[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [ALU_WIDTH-1:0] ALU_NONE = 6'd0;
  localparam logic [ALU_WIDTH-1:0] ALU_ADD  = 6'd1;
  localparam logic [ALU_WIDTH-1:0] ALU_SUB  = 6'd2;
  localparam logic [ALU_WIDTH-1:0] ALU_MUL  = 6'd3;
  localparam logic [ALU_WIDTH-1:0] ALU_SRL  = 6'd4;
  localparam logic [ALU_WIDTH-1:0] ALU_SLL  = 6'd5;
  localparam logic [ALU_WIDTH-1:0] ALU_AND  = 6'd6;
  localparam logic [ALU_WIDTH-1:0] ALU_OR   = 6'd7;
  localparam logic [ALU_WIDTH-1:0] ALU_NOR  = 6'd8;
  localparam logic [ALU_WIDTH-1:0] ALU_SLT  = 6'd9;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_e;

  // CTRL bit positions; CTRL[31:29] are tied to zero
  localparam int CB_PC_LOAD   = 28;
  localparam int CB_SP_LOAD   = 27;
  localparam int CB_PC_SEL_1  = 26;
  localparam int CB_PC_SEL_2  = 25;
  localparam int CB_PC_SEL_3  = 24;
  localparam int CB_R1_SEL_1  = 23;
  localparam int CB_IR_LOAD   = 22;
  localparam int CB_WA_SEL_1  = 21;
  localparam int CB_WA_SEL_2  = 20;
  localparam int CB_WA_SEL_3  = 19;
  localparam int CB_WD_SEL_1  = 18;
  localparam int CB_WD_SEL_2  = 17;
  localparam int CB_WD_SEL_3  = 16;
  localparam int CB_OP1_SEL_1 = 15;
  localparam int CB_OP2_SEL_1 = 14;
  localparam int CB_OP2_SEL_2 = 13;
  localparam int CB_OP2_SEL_3 = 12;
  localparam int CB_OP2_SEL_4 = 11;
  localparam int CB_REG_R     = 10;
  localparam int CB_REG_W     = 9;
  localparam int CB_ALU_MSB   = 8;
  localparam int CB_ALU_LSB   = 3;
  localparam int CB_MA_SEL_1  = 2;
  localparam int CB_MA_SEL_2  = 1;
  localparam int CB_MD_SEL_1  = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map (state, opcode, funct, ZERO) -> {CTRL, READ, WRITE}.
// Undefined encodings leave every class flag low and so fall through as a NOP.
module ctrl_decode
  import control_unit_pkg::*;
(
  input  state_e                state_i,
  input  logic [5:0]            opcode_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic                  read_o,
  output logic                  write_o
);

  logic [ALU_WIDTH-1:0] alu_op;
  logic r_alu, shift, jr, imm_alu, sext, lui, lw, sw, beq, bne, jmp, jal, push, pop;
  logic held, writes_reg;

  always_comb begin
    alu_op = ALU_NONE;
    r_alu = 1'b0; shift = 1'b0; jr = 1'b0; imm_alu = 1'b0; sext = 1'b0; lui = 1'b0;
    lw = 1'b0; sw = 1'b0; beq = 1'b0; bne = 1'b0; jmp = 1'b0; jal = 1'b0;
    push = 1'b0; pop = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      case (funct_i)
        FN_ADD:  begin r_alu = 1'b1; alu_op = ALU_ADD; end
        FN_SUB:  begin r_alu = 1'b1; alu_op = ALU_SUB; end
        FN_MUL:  begin r_alu = 1'b1; alu_op = ALU_MUL; end
        FN_AND:  begin r_alu = 1'b1; alu_op = ALU_AND; end
        FN_OR:   begin r_alu = 1'b1; alu_op = ALU_OR;  end
        FN_NOR:  begin r_alu = 1'b1; alu_op = ALU_NOR; end
        FN_SLT:  begin r_alu = 1'b1; alu_op = ALU_SLT; end
        FN_SLL:  begin r_alu = 1'b1; shift = 1'b1; alu_op = ALU_SLL; end
        FN_SRL:  begin r_alu = 1'b1; shift = 1'b1; alu_op = ALU_SRL; end
        FN_JR:   jr = 1'b1;
        default: ;
      endcase
    end else begin
      case (opcode_i)
        OP_ADDI: begin imm_alu = 1'b1; sext = 1'b1; alu_op = ALU_ADD; end
        OP_MULI: begin imm_alu = 1'b1; sext = 1'b1; alu_op = ALU_MUL; end
        OP_ANDI: begin imm_alu = 1'b1; alu_op = ALU_AND; end
        OP_ORI:  begin imm_alu = 1'b1; alu_op = ALU_OR;  end
        OP_SLTI: begin imm_alu = 1'b1; sext = 1'b1; alu_op = ALU_SLT; end
        OP_LUI:  lui = 1'b1;
        OP_BEQ:  begin beq = 1'b1; alu_op = ALU_SUB; end
        OP_BNE:  begin bne = 1'b1; alu_op = ALU_SUB; end
        OP_LW:   begin lw = 1'b1; sext = 1'b1; alu_op = ALU_ADD; end
        OP_SW:   begin sw = 1'b1; sext = 1'b1; alu_op = ALU_ADD; end
        OP_JMP:  jmp = 1'b1;
        OP_JAL:  jal = 1'b1;
        OP_PUSH: begin push = 1'b1; alu_op = ALU_SUB; end
        OP_POP:  begin pop = 1'b1; alu_op = ALU_ADD; end
        default: ;
      endcase
    end
  end

  // ALU operand selects stay put from EXECUTE onward so ZERO is still valid in WRITEBACK
  assign held       = (state_i == ST_EXECUTE) || (state_i == ST_MEMORY) || (state_i == ST_WRITEBACK);
  assign writes_reg = r_alu | imm_alu | lui | lw | jal | pop;

  always_comb begin
    ctrl_o  = '0;
    read_o  = 1'b0;
    write_o = 1'b0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o[CB_MA_SEL_2] = 1'b1;
        ctrl_o[CB_IR_LOAD]  = 1'b1;
        read_o              = 1'b1;
      end
      ST_MEMORY: begin
        read_o              = lw | pop;
        write_o             = sw | push;
        ctrl_o[CB_MA_SEL_1] = push;
        ctrl_o[CB_MD_SEL_1] = push;
      end
      ST_WRITEBACK: begin
        ctrl_o[CB_PC_LOAD]  = 1'b1;
        ctrl_o[CB_PC_SEL_1] = ~jr;
        ctrl_o[CB_PC_SEL_2] = (beq & zero_i) | (bne & ~zero_i);
        ctrl_o[CB_PC_SEL_3] = ~(jmp | jal);
        ctrl_o[CB_SP_LOAD]  = push | pop;
        ctrl_o[CB_REG_W]    = writes_reg;
        ctrl_o[CB_WA_SEL_1] = imm_alu | lui | lw;
        ctrl_o[CB_WA_SEL_2] = jal;
        ctrl_o[CB_WA_SEL_3] = r_alu | imm_alu | lui | lw;
        ctrl_o[CB_WD_SEL_1] = lw | pop;
        ctrl_o[CB_WD_SEL_2] = lui;
        ctrl_o[CB_WD_SEL_3] = writes_reg & ~jal;
      end
      default: ;
    endcase
    if ((state_i == ST_DECODE) || (state_i == ST_EXECUTE) || (state_i == ST_MEMORY))
      ctrl_o[CB_REG_R] = 1'b1;
    if ((state_i != ST_INIT) && (state_i != ST_FETCH))
      ctrl_o[CB_R1_SEL_1] = push;
    if (held) begin
      ctrl_o[CB_ALU_MSB:CB_ALU_LSB] = alu_op;
      ctrl_o[CB_OP1_SEL_1]          = push | pop;
      ctrl_o[CB_OP2_SEL_1]          = shift;
      ctrl_o[CB_OP2_SEL_2]          = sext;
      ctrl_o[CB_OP2_SEL_3]          = shift | push | pop;
      ctrl_o[CB_OP2_SEL_4]          = (r_alu & ~shift) | jr | beq | bne;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Five-phase sequencer for the cs147sec05 processor; holds only the state register,
// all control outputs come from ctrl_decode.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
  input  logic                   ZERO,
  output logic [CTRL_WIDTH-1:0]  CTRL,
  output logic                   READ,
  output logic                   WRITE
);

  state_e state_q, state_d;
  logic   unused_instr_fields;

  // Register/immediate fields are consumed by the datapath, not by sequencing
  assign unused_instr_fields = ^INSTRUCTION[25:6];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:      state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_MEMORY;
      ST_MEMORY:    state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_INIT;
    endcase
  end

  ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (INSTRUCTION[31:26]),
    .funct_i  (INSTRUCTION[5:0]),
    .zero_i   (ZERO),
    .ctrl_o   (CTRL),
    .read_o   (READ),
    .write_o  (WRITE)
  );

endmodule
